// File: rtl/de3d_tc_pkg.sv
// de3d_tc_pkg
//  Shared definitions for the texture-cache tag responder.
//  - TC_TAG_W / TC_IDX_W : default tag and index widths
//  - tc_state_e          : responder FSM state encoding
//  - tc_bank_e           : bank ids (ee, eo, oe, oo)
//  - lowest_bank()       : priority encoder, lowest set bit of a 4-bit mask
package de3d_tc_pkg;

    localparam int TC_TAG_W = 12;
    localparam int TC_IDX_W = 5;
    localparam int TC_BANKS = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMP  = 3'd1,
        ST_FILL = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } tc_state_e;

    typedef enum logic [1:0] {
        BANK_EE = 2'd0,
        BANK_EO = 2'd1,
        BANK_OE = 2'd2,
        BANK_OO = 2'd3
    } tc_bank_e;

    // Lowest-numbered set bit wins; an empty mask returns bank 0.
    function automatic logic [1:0] lowest_bank(input logic [3:0] m);
        logic [1:0] b;
        b = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                b = i[1:0];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/de3d_tc_tag_bank.sv
// de3d_tc_tag_bank
//  One texture-cache tag bank: 2**IDX_W entries of {valid, tag}.
//  The read index is registered when a lookup is accepted; the hit output
//  compares the entry at that index with cmp_tag. The single write port
//  installs a tag at the same registered index. clr drops every valid bit.
//  Ports:
//   clk, rst       clock, async active-high reset
//   rd_en, rd_idx  register a new lookup index
//   cmp_tag        compare tag for the registered index
//   wr_en, wr_tag  install wr_tag at the registered index and mark it valid
//   clr            clear all valid bits (wins over a write)
//   hit            entry at the registered index is valid and matches
//   cur_idx        registered index
module de3d_tc_tag_bank
    import de3d_tc_pkg::*;
#(
    parameter int TAG_W = TC_TAG_W,
    parameter int IDX_W = TC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] cmp_tag,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr,
    output logic             hit,
    output logic [IDX_W-1:0] cur_idx
);

    localparam int DEPTH = 1 << IDX_W;

    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [TAG_W-1:0] tag_d   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Next-state for index, tag array and valid bits.
    always_comb begin
        idx_d   = idx_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (rd_en) begin
            idx_d = rd_idx;
        end else begin
            idx_d = idx_q;
        end
        if (wr_en) begin
            tag_d[idx_q] = wr_tag;
        end else begin
            tag_d = tag_q;
        end
        if (clr) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[idx_q] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Storage flops; reset leaves every entry invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign hit     = valid_q[idx_q] && (tag_q[idx_q] == cmp_tag);
    assign cur_idx = idx_q;

endmodule

// File: rtl/de3d_tc_tag_resp.sv
// de3d_tc_tag_resp
//  Tag-side responder for the four even/odd texture-cache tag banks.
//  A push latches per-bank indices and compare tags; banks that miss are
//  filled one at a time (lowest bank first) through a fill_req/fill_ack
//  handshake, then tc_done pulses with the per-bank miss mask.
//  Ports:
//   de_clk, de_rst                 clock, async active-high reset
//   push_uv_dd, current_clip_dd    lookup strobe and clip flag
//   xx_tag_adr_rd, xx_tag_cmp      per-bank index and compare tag
//   tc_inv                         invalidate all tags
//   fill_ack                       fill accepted and data returned
//   tc_busy                        lookup in progress
//   fill_req/bank/idx/tag          fill request, held until fill_ack
//   tc_done, miss_mask             completion pulse and miss mask
//   push_err                       sticky: push seen while busy
module de3d_tc_tag_resp
    import de3d_tc_pkg::*;
#(
    parameter int TAG_W = TC_TAG_W,
    parameter int IDX_W = TC_IDX_W
) (
    input  logic             de_clk,
    input  logic             de_rst,
    input  logic             push_uv_dd,
    input  logic             current_clip_dd,
    input  logic [IDX_W-1:0] ee_tag_adr_rd,
    input  logic [IDX_W-1:0] eo_tag_adr_rd,
    input  logic [IDX_W-1:0] oe_tag_adr_rd,
    input  logic [IDX_W-1:0] oo_tag_adr_rd,
    input  logic [TAG_W-1:0] ee_tag_cmp,
    input  logic [TAG_W-1:0] eo_tag_cmp,
    input  logic [TAG_W-1:0] oe_tag_cmp,
    input  logic [TAG_W-1:0] oo_tag_cmp,
    input  logic             tc_inv,
    input  logic             fill_ack,
    output logic             tc_busy,
    output logic             fill_req,
    output logic [1:0]       fill_bank,
    output logic [IDX_W-1:0] fill_idx,
    output logic [TAG_W-1:0] fill_tag,
    output logic             tc_done,
    output logic [3:0]       miss_mask,
    output logic             push_err
);

    tc_state_e        state_q, state_d;
    logic [TAG_W-1:0] cmp_q [TC_BANKS];
    logic [TAG_W-1:0] cmp_d [TC_BANKS];
    logic             clip_q, clip_d;
    logic [3:0]       outst_q, outst_d;
    logic [3:0]       miss_mask_q, miss_mask_d;
    logic             fill_req_q, fill_req_d;
    logic [1:0]       fill_bank_q, fill_bank_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic             tc_busy_q, tc_busy_d;
    logic             tc_done_q, tc_done_d;
    logic             inv_pend_q, inv_pend_d;
    logic             push_err_q, push_err_d;

    logic [IDX_W-1:0] adr_in_s  [TC_BANKS];
    logic [TAG_W-1:0] cmp_in_s  [TC_BANKS];
    logic [IDX_W-1:0] cur_idx_s [TC_BANKS];
    logic [3:0]       hit_s;
    logic [3:0]       miss_s;
    logic [3:0]       wr_en_s;
    logic [3:0]       outst_left_s;
    logic [1:0]       next_bank_s;
    logic             push_ok_s;
    logic             clr_s;

    assign adr_in_s[0] = ee_tag_adr_rd;
    assign adr_in_s[1] = eo_tag_adr_rd;
    assign adr_in_s[2] = oe_tag_adr_rd;
    assign adr_in_s[3] = oo_tag_adr_rd;
    assign cmp_in_s[0] = ee_tag_cmp;
    assign cmp_in_s[1] = eo_tag_cmp;
    assign cmp_in_s[2] = oe_tag_cmp;
    assign cmp_in_s[3] = oo_tag_cmp;

    // Only an idle responder takes a push; DONE still counts as busy.
    assign push_ok_s    = push_uv_dd && (state_q == ST_IDLE);
    assign miss_s       = clip_q ? 4'b0000 : ~hit_s;
    assign next_bank_s  = lowest_bank(outst_q);
    assign outst_left_s = outst_q & ~(4'b0001 << fill_bank_q);
    // Invalidate immediately when idle; a pending one lands on the DONE->IDLE
    // edge, after the last fill write has already happened.
    assign clr_s = ((state_q == ST_IDLE) && tc_inv) ||
                   ((state_q == ST_DONE) && (inv_pend_q || tc_inv));

    for (genvar b = 0; b < TC_BANKS; b++) begin : g_bank
        assign wr_en_s[b] = (state_q == ST_WAIT) && fill_ack && (fill_bank_q == 2'(b));

        de3d_tc_tag_bank #(
            .TAG_W (TAG_W),
            .IDX_W (IDX_W)
        ) u_bank (
            .clk     (de_clk),
            .rst     (de_rst),
            .rd_en   (push_ok_s),
            .rd_idx  (adr_in_s[b]),
            .cmp_tag (cmp_q[b]),
            .wr_en   (wr_en_s[b]),
            .wr_tag  (fill_tag_q),
            .clr     (clr_s),
            .hit     (hit_s[b]),
            .cur_idx (cur_idx_s[b])
        );
    end

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cmp_d       = cmp_q;
        clip_d      = clip_q;
        outst_d     = outst_q;
        miss_mask_d = miss_mask_q;
        fill_req_d  = fill_req_q;
        fill_bank_d = fill_bank_q;
        fill_idx_d  = fill_idx_q;
        fill_tag_d  = fill_tag_q;
        tc_busy_d   = tc_busy_q;
        tc_done_d   = 1'b0;
        inv_pend_d  = inv_pend_q;
        push_err_d  = push_err_q | (push_uv_dd && (state_q != ST_IDLE));

        if (tc_inv && ((state_q == ST_CMP) || (state_q == ST_FILL) || (state_q == ST_WAIT))) begin
            inv_pend_d = 1'b1;
        end else begin
            inv_pend_d = inv_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (push_ok_s) begin
                    cmp_d     = cmp_in_s;
                    clip_d    = current_clip_dd;
                    tc_busy_d = 1'b1;
                    state_d   = ST_CMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                miss_mask_d = miss_s;
                outst_d     = miss_s;
                if (miss_s == 4'b0000) begin
                    tc_done_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                fill_req_d  = 1'b1;
                fill_bank_d = next_bank_s;
                fill_idx_d  = cur_idx_s[next_bank_s];
                fill_tag_d  = cmp_q[next_bank_s];
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (fill_ack) begin
                    fill_req_d = 1'b0;
                    outst_d    = outst_left_s;
                    if (outst_left_s != 4'b0000) begin
                        state_d = ST_FILL;
                    end else begin
                        tc_done_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                tc_busy_d  = 1'b0;
                inv_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                fill_req_d = 1'b0;
                tc_busy_d  = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops fill_req at once.
    always_ff @(posedge de_clk or posedge de_rst) begin
        if (de_rst) begin
            state_q     <= ST_IDLE;
            clip_q      <= 1'b0;
            outst_q     <= 4'b0000;
            miss_mask_q <= 4'b0000;
            fill_req_q  <= 1'b0;
            fill_bank_q <= 2'd0;
            fill_idx_q  <= '0;
            fill_tag_q  <= '0;
            tc_busy_q   <= 1'b0;
            tc_done_q   <= 1'b0;
            inv_pend_q  <= 1'b0;
            push_err_q  <= 1'b0;
            for (int i = 0; i < TC_BANKS; i++) begin
                cmp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            clip_q      <= clip_d;
            outst_q     <= outst_d;
            miss_mask_q <= miss_mask_d;
            fill_req_q  <= fill_req_d;
            fill_bank_q <= fill_bank_d;
            fill_idx_q  <= fill_idx_d;
            fill_tag_q  <= fill_tag_d;
            tc_busy_q   <= tc_busy_d;
            tc_done_q   <= tc_done_d;
            inv_pend_q  <= inv_pend_d;
            push_err_q  <= push_err_d;
            cmp_q       <= cmp_d;
        end
    end

    assign tc_busy   = tc_busy_q;
    assign fill_req  = fill_req_q;
    assign fill_bank = fill_bank_q;
    assign fill_idx  = fill_idx_q;
    assign fill_tag  = fill_tag_q;
    assign tc_done   = tc_done_q;
    assign miss_mask = miss_mask_q;
    assign push_err  = push_err_q;

endmodule

// File: tb/tb_de3d_tc_tag_resp.sv
// tb_de3d_tc_tag_resp
//  Directed bench for de3d_tc_tag_resp: cold fills, hits, partial misses,
//  clipping, invalidation (idle, with push, during a fill), busy pushes and
//  asynchronous reset in the middle of a fill.
module tb_de3d_tc_tag_resp;

    logic        de_clk = 1'b0;
    logic        de_rst = 1'b1;
    logic        push_uv_dd = 1'b0;
    logic        current_clip_dd = 1'b0;
    logic [4:0]  ee_tag_adr_rd = 5'd0, eo_tag_adr_rd = 5'd0;
    logic [4:0]  oe_tag_adr_rd = 5'd0, oo_tag_adr_rd = 5'd0;
    logic [11:0] ee_tag_cmp = 12'd0, eo_tag_cmp = 12'd0;
    logic [11:0] oe_tag_cmp = 12'd0, oo_tag_cmp = 12'd0;
    logic        tc_inv = 1'b0;
    logic        fill_ack = 1'b0;
    logic        tc_busy, fill_req, tc_done, push_err;
    logic [1:0]  fill_bank;
    logic [4:0]  fill_idx;
    logic [11:0] fill_tag;
    logic [3:0]  miss_mask;

    int check_count = 0;
    int error_count = 0;

    de3d_tc_tag_resp dut (
        .de_clk          (de_clk),
        .de_rst          (de_rst),
        .push_uv_dd      (push_uv_dd),
        .current_clip_dd (current_clip_dd),
        .ee_tag_adr_rd   (ee_tag_adr_rd),
        .eo_tag_adr_rd   (eo_tag_adr_rd),
        .oe_tag_adr_rd   (oe_tag_adr_rd),
        .oo_tag_adr_rd   (oo_tag_adr_rd),
        .ee_tag_cmp      (ee_tag_cmp),
        .eo_tag_cmp      (eo_tag_cmp),
        .oe_tag_cmp      (oe_tag_cmp),
        .oo_tag_cmp      (oo_tag_cmp),
        .tc_inv          (tc_inv),
        .fill_ack        (fill_ack),
        .tc_busy         (tc_busy),
        .fill_req        (fill_req),
        .fill_bank       (fill_bank),
        .fill_idx        (fill_idx),
        .fill_tag        (fill_tag),
        .tc_done         (tc_done),
        .miss_mask       (miss_mask),
        .push_err        (push_err)
    );

    always #5 de_clk = ~de_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge de_clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] idx, input logic [11:0] c0, input logic [11:0] c1,
                           input logic [11:0] c2, input logic [11:0] c3);
        ee_tag_adr_rd = idx; eo_tag_adr_rd = idx; oe_tag_adr_rd = idx; oo_tag_adr_rd = idx;
        ee_tag_cmp = c0; eo_tag_cmp = c1; oe_tag_cmp = c2; oo_tag_cmp = c3;
    endtask

    // Push one lookup and serve it to completion. Fills are expected in
    // ascending bank order over exp_mask, each acked ack_dly cycles after
    // fill_req is first seen. exp_lat > 0 checks the push-to-done distance.
    task automatic lookup(input string name, input logic [4:0] idx,
                          input logic [11:0] c0, input logic [11:0] c1,
                          input logic [11:0] c2, input logic [11:0] c3,
                          input logic clip, input logic inv_with_push,
                          input logic [3:0] exp_mask, input int ack_dly,
                          input logic inv_in_wait, input int exp_lat);
        logic [11:0] cmps [4];
        logic [3:0]  rem;
        int          cyc;
        int          b;
        int          w;
        bit          done;
        cmps[0] = c0; cmps[1] = c1; cmps[2] = c2; cmps[3] = c3;
        set_req(idx, c0, c1, c2, c3);
        current_clip_dd = clip;
        tc_inv = inv_with_push;
        push_uv_dd = 1'b1;
        tick();
        push_uv_dd = 1'b0;
        tc_inv = 1'b0;
        current_clip_dd = 1'b0;
        check_eq({name, "_busy"}, {31'd0, tc_busy}, 32'd1);
        rem = exp_mask;
        cyc = 1;
        done = 1'b0;
        while (!done && cyc < 100) begin
            if (tc_done) begin
                done = 1'b1;
                check_eq({name, "_mask"}, {28'd0, miss_mask}, {28'd0, exp_mask});
                check_eq({name, "_fills_left"}, {28'd0, rem}, 32'd0);
                if (exp_lat > 0) begin
                    check_eq({name, "_latency"}, cyc, exp_lat);
                end
            end else if (fill_req) begin
                b = 4;
                for (int i = 3; i >= 0; i--) begin
                    if (rem[i]) b = i;
                end
                if (b == 4) begin
                    check_eq({name, "_extra_fill_req"}, {31'd0, fill_req}, 32'd0);
                end else begin
                    check_eq({name, "_fill_bank"}, {30'd0, fill_bank}, b);
                    check_eq({name, "_fill_idx"}, {27'd0, fill_idx}, {27'd0, idx});
                    check_eq({name, "_fill_tag"}, {20'd0, fill_tag}, {20'd0, cmps[b]});
                    rem[b] = 1'b0;
                end
                w = ack_dly;
                if (inv_in_wait) begin
                    tc_inv = 1'b1;
                    tick();
                    tc_inv = 1'b0;
                    cyc++;
                    w--;
                end
                repeat (w) begin
                    tick();
                    cyc++;
                end
                check_eq({name, "_req_hold"}, {31'd0, fill_req}, 32'd1);
                fill_ack = 1'b1;
                tick();
                cyc++;
                fill_ack = 1'b0;
                check_eq({name, "_req_drop"}, {31'd0, fill_req}, 32'd0);
            end else begin
                tick();
                cyc++;
            end
        end
        if (!done) begin
            check_eq({name, "_timeout"}, {31'd0, tc_done}, 32'd1);
        end
        tick();
        check_eq({name, "_done_pulse"}, {31'd0, tc_done}, 32'd0);
        check_eq({name, "_idle"}, {31'd0, tc_busy}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        tick();
        tick();
        check_eq("rst_busy", {31'd0, tc_busy}, 32'd0);
        check_eq("rst_fill_req", {31'd0, fill_req}, 32'd0);
        check_eq("rst_done", {31'd0, tc_done}, 32'd0);
        check_eq("rst_mask", {28'd0, miss_mask}, 32'd0);
        check_eq("rst_push_err", {31'd0, push_err}, 32'd0);
        de_rst = 1'b0;
        tick();

        // 1: cold fills in bank order, 2 + 4*3 cycles
        tc_inv = 1'b1;
        tick();
        tc_inv = 1'b0;
        lookup("t1_cold", 5'd3, 12'h123, 12'h123, 12'h123, 12'h123, 1'b0, 1'b0, 4'hF, 1, 1'b0, 14);

        // 2: same push hits everywhere; a stray ack while idle is ignored
        fill_ack = 1'b1;
        tick();
        fill_ack = 1'b0;
        lookup("t2_hit", 5'd3, 12'h123, 12'h123, 12'h123, 12'h123, 1'b0, 1'b0, 4'h0, 1, 1'b0, 2);

        // 3: eo/oo miss, then the new tags hit
        lookup("t3_part", 5'd3, 12'h123, 12'h124, 12'h123, 12'h124, 1'b0, 1'b0, 4'hA, 1, 1'b0, 8);
        lookup("t3_rehit", 5'd3, 12'h123, 12'h124, 12'h123, 12'h124, 1'b0, 1'b0, 4'h0, 1, 1'b0, 2);

        // tc_inv together with a push: compare sees the cleared store
        lookup("t4_invpush", 5'd3, 12'h123, 12'h124, 12'h123, 12'h124, 1'b0, 1'b1, 4'hF, 1, 1'b0, 14);

        // 4: clipped push on a cold cache
        tc_inv = 1'b1;
        tick();
        tc_inv = 1'b0;
        lookup("t4_clip", 5'd3, 12'h123, 12'h123, 12'h123, 12'h123, 1'b1, 1'b0, 4'h0, 1, 1'b0, 2);

        // 5: warm up, then tc_inv during WAIT with a slow ack
        lookup("t5_warm", 5'd3, 12'h123, 12'h123, 12'h123, 12'h123, 1'b0, 1'b0, 4'hF, 1, 1'b0, 14);
        lookup("t5_invwait", 5'd3, 12'h123, 12'h125, 12'h123, 12'h123, 1'b0, 1'b0, 4'h2, 5, 1'b1, -1);
        lookup("t5_after", 5'd3, 12'h123, 12'h125, 12'h123, 12'h123, 1'b0, 1'b0, 4'hF, 1, 1'b0, -1);
        check_eq("t5_push_err", {31'd0, push_err}, 32'd0);

        // 6: push while busy, then async reset in WAIT
        set_req(5'd3, 12'h200, 12'h200, 12'h200, 12'h200);
        push_uv_dd = 1'b1;
        tick();
        tick();
        push_uv_dd = 1'b0;
        check_eq("t6_push_err", {31'd0, push_err}, 32'd1);
        n = 0;
        while (!fill_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("t6_wait_req", {31'd0, fill_req}, 32'd1);
        check_eq("t6_push_err_sticky", {31'd0, push_err}, 32'd1);
        #2;
        de_rst = 1'b1;
        #1;
        check_eq("t6_rst_fill_req", {31'd0, fill_req}, 32'd0);
        check_eq("t6_rst_push_err", {31'd0, push_err}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, tc_busy}, 32'd0);
        tick();
        de_rst = 1'b0;
        tick();
        lookup("t6_after_rst", 5'd3, 12'h123, 12'h125, 12'h123, 12'h123, 1'b0, 1'b0, 4'hF, 1, 1'b0, 14);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
